// File: rtl/pipe_pkg.sv
// Shared pipeline types: skid buffer occupancy states and writeback select codes.
// Imported by the EX/MEM register and its two-entry buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready buffer over a packed payload, with flush.
// in_ready depends only on registered state, never on out_ready.
module skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t state, state_nx;
    logic [W-1:0] main_q, skid_q;
    logic acc, con;
    logic ld_main, ld_skid, mv_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign acc       = in_valid & in_ready;
    assign con       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_nx = BUSY;
                    ld_main  = 1'b1;
                end
            end
            BUSY: begin
                if (acc && con) begin
                    ld_main = 1'b1;
                end else if (acc) begin
                    state_nx = FULL;
                    ld_skid  = 1'b1;
                end else if (con) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (con) begin
                    state_nx = BUSY;
                    mv_skid  = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // Flush wins over everything; stale payload stays but is never valid.
        if (flush) begin
            state_nx = EMPTY;
            ld_main  = 1'b0;
            ld_skid  = 1'b0;
            mv_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main) begin
                main_q <= in_data;
            end else if (mv_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ff3_skid.sv
// EX->MEM pipeline register with skid buffering, flush and a stall counter.
// Write enables are gated by validM so bubbles never write state.
module ff3_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              validE,
    output logic              readyE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MemWriteE,
    input  logic [DATA_W-1:0] ALUoutE,
    input  logic [2:0]        funct3E,
    input  logic [REG_W-1:0]  RdE,
    input  logic [DATA_W-1:0] inc_PCE,
    output logic              validM,
    input  logic              readyM,
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUoutM,
    output logic [2:0]        funct3M,
    output logic [REG_W-1:0]  RdM,
    output logic [DATA_W-1:0] inc_PCM,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 1 + 2 + 1 + DATA_W + 3 + REG_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0] pl_in, pl_out;
    logic rw_q, mw_q;

    assign pl_in = {RegWriteE, ResultSrcE, MemWriteE, ALUoutE,
                    funct3E, RdE, inc_PCE};

    skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (validE),
        .in_ready  (readyE),
        .in_data   (pl_in),
        .out_valid (validM),
        .out_ready (readyM),
        .out_data  (pl_out)
    );

    assign {rw_q, ResultSrcM, mw_q, ALUoutM,
            funct3M, RdM, inc_PCM} = pl_out;

    assign RegWriteM = rw_q & validM;
    assign MemWriteM = mw_q & validM;

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (validM && !readyM && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ff3_skid.sv
// Randomised and directed bench for ff3_skid against a queue-based model.
// Model: FIFO of up to two entries plus a saturating stall count.
module tb_ff3_skid;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic validE = 1'b0;
    logic readyE;
    logic RegWriteE = 1'b0;
    logic [1:0] ResultSrcE = 2'b00;
    logic MemWriteE = 1'b0;
    logic [DW-1:0] ALUoutE = '0;
    logic [2:0] funct3E = '0;
    logic [RW-1:0] RdE = '0;
    logic [DW-1:0] inc_PCE = '0;
    logic validM;
    logic readyM = 1'b0;
    logic RegWriteM;
    logic [1:0] ResultSrcM;
    logic MemWriteM;
    logic [DW-1:0] ALUoutM;
    logic [2:0] funct3M;
    logic [RW-1:0] RdM;
    logic [DW-1:0] inc_PCM;
    logic [CW-1:0] stall_cnt;

    ff3_skid #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .validE     (validE),
        .readyE     (readyE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .ALUoutE    (ALUoutE),
        .funct3E    (funct3E),
        .RdE        (RdE),
        .inc_PCE    (inc_PCE),
        .validM     (validM),
        .readyM     (readyM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUoutM    (ALUoutM),
        .funct3M    (funct3M),
        .RdM        (RdM),
        .inc_PCM    (inc_PCM),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [1:0]    rs;
        logic          mw;
        logic [DW-1:0] alu;
        logic [2:0]    f3;
        logic [RW-1:0] rd;
        logic [DW-1:0] pc;
    } pl_t;

    pl_t q[$];
    int  mcnt = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pl_t cur_in();
        pl_t p;
        p.rw  = RegWriteE;
        p.rs  = ResultSrcE;
        p.mw  = MemWriteE;
        p.alu = ALUoutE;
        p.f3  = funct3E;
        p.rd  = RdE;
        p.pc  = inc_PCE;
        return p;
    endfunction

    task automatic compare();
        bit v;
        v = (q.size() > 0);
        check("validM", validM, v);
        check("readyE", readyE, q.size() < 2);
        check("stall_cnt", stall_cnt, mcnt);
        if (v) begin
            check("RegWriteM", RegWriteM, q[0].rw);
            check("MemWriteM", MemWriteM, q[0].mw);
            check("ALUoutM", ALUoutM, q[0].alu);
            check("RdM", RdM, q[0].rd);
            check("ResultSrcM", ResultSrcM, q[0].rs);
            check("funct3M", funct3M, q[0].f3);
            check("inc_PCM", inc_PCM, q[0].pc);
        end else begin
            check("RegWriteM_gated", RegWriteM, 0);
            check("MemWriteM_gated", MemWriteM, 0);
        end
    endtask

    // One clock: the model moves with the inputs held over the edge.
    task automatic step();
        bit acc, con;
        pl_t p;
        p   = cur_in();
        acc = validE && (q.size() < 2);
        con = (q.size() > 0) && readyM;
        if (q.size() > 0 && !readyM && mcnt < CMAX) mcnt++;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        compare();
    endtask

    task automatic drive(input bit v, input bit rdy, input bit fl,
                         input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                         input bit rw, input bit mw);
        validE     = v;
        readyM     = rdy;
        flush      = fl;
        ALUoutE    = alu;
        RdE        = rd;
        RegWriteE  = rw;
        MemWriteE  = mw;
        ResultSrcE = 2'($urandom_range(0, 2));
        funct3E    = 3'($urandom);
        inc_PCE    = $urandom;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_validM"}, validM, 0);
        check({tag, "_readyE"}, readyE, 1);
        check({tag, "_RegWriteM"}, RegWriteM, 0);
        check({tag, "_MemWriteM"}, MemWriteM, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
        check({tag, "_ALUoutM"}, ALUoutM, 0);
        check({tag, "_RdM"}, RdM, 0);
    endtask

    initial begin
        #12;
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // streaming
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, DW'(32'h10 + i), RW'(i), 1, 0);
            step();
            check("stream_alu", ALUoutM, 32'h10 + i);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        step();

        // stall with skid
        drive(1, 1, 0, 32'hA, 5, 1, 0);
        step();
        drive(1, 0, 0, 32'hB, 6, 1, 0);
        step();
        check("skid_readyE", readyE, 0);
        check("skid_RdM_hold", RdM, 5);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        check("skid_RdM_second", RdM, 6);
        step();
        check("skid_drained", validM, 0);

        // flush while FULL
        drive(1, 0, 0, 32'h100, 1, 1, 1);
        step();
        drive(1, 0, 0, 32'h101, 2, 1, 1);
        step();
        drive(1, 0, 1, 32'hBAD, 3, 1, 1);
        step();
        check("flush_validM", validM, 0);
        check("flush_RegWriteM", RegWriteM, 0);
        check("flush_readyE", readyE, 1);
        // flush in BUSY with a same-cycle accept
        drive(1, 0, 0, 32'h200, 4, 1, 1);
        step();
        drive(1, 1, 1, 32'hBAD, 3, 1, 1);
        step();
        drive(0, 1, 0, 0, 0, 1, 1);
        step();
        check("flush_noaccept", validM, 0);

        // bubble gating
        for (int i = 0; i < 4; i++) begin
            drive(0, i[0], 0, $urandom, 7, 1, 1);
            step();
            check("bubble_RegWriteM", RegWriteM, 0);
            check("bubble_MemWriteM", MemWriteM, 0);
        end

        // async reset mid-stall in FULL
        drive(1, 0, 0, 32'h300, 8, 1, 1);
        step();
        drive(1, 0, 0, 32'h301, 9, 1, 1);
        step();
        check("pre_rst_full", readyE, 0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mcnt = 0;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 32'hDEADBEEF, 10, 0, 0);
        step();
        check("post_rst_alu", ALUoutM, 32'hDEADBEEF);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();

        // stall counter saturation
        drive(1, 0, 0, 32'h400, 11, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("sat_cnt", stall_cnt, (i + 1 < CMAX) ? i + 1 : CMAX);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        check("sat_after_flush", stall_cnt, CMAX);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        check("sat_hold_idle", stall_cnt, CMAX);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mcnt = 0;
        check("cnt_rst", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0, $urandom, RW'($urandom),
                  1'($urandom), 1'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
